// File: rtl/simon_decrypt_iter.sv
// Iterative Simon32/64 decryptor: on-chip key expansion, one round per clock.
// Round keys are kept across blocks until the next key load or reset.
module simon_decrypt_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic [63:0] keytext,
    output logic        key_ready,
    input  logic        in_valid,
    input  logic [31:0] ciphertext,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] plaintext,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        READY,
        DEC,
        DONE
    } state_t;

    // bit j holds z0[j]; only bits 27:0 are ever selected
    localparam logic [31:0] ZTAB = 32'h0386_A45F;

    state_t      state;
    state_t      state_nx;
    logic [15:0] rk [32];
    logic [4:0]  kcnt;
    logic [4:0]  rcnt;
    logic [15:0] x;
    logic [15:0] y;
    logic        key_acc;
    logic        ct_acc;

    logic [15:0] km1;
    logic [15:0] km3;
    logic [15:0] km4;
    logic [15:0] kt;
    logic [15:0] knew;
    logic [4:0]  zidx;
    logic [15:0] fy;
    logic [15:0] ynew;

    always_comb begin
        km1  = rk[kcnt - 5'd1];
        km3  = rk[kcnt - 5'd3];
        km4  = rk[kcnt - 5'd4];
        zidx = kcnt - 5'd4;
        kt   = {km1[2:0], km1[15:3]} ^ km3;
        knew = ~km4 ^ kt ^ {kt[0], kt[15:1]}
             ^ {15'd0, ZTAB[zidx]} ^ 16'h0003;
    end

    always_comb begin
        fy   = ({y[14:0], y[15]} & {y[7:0], y[15:8]})
             ^ {y[13:0], y[15:14]};
        ynew = x ^ fy ^ rk[rcnt];
    end

    always_comb begin
        state_nx  = state;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        key_acc   = 1'b0;
        ct_acc    = 1'b0;
        unique case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_load) begin
                    key_acc  = 1'b1;
                    state_nx = KEYEXP;
                end
            end
            KEYEXP: begin
                if (kcnt == 5'd31) state_nx = READY;
            end
            READY: begin
                key_ready = 1'b1;
                // a pending key load wins, so ciphertext is refused
                in_ready  = ~key_load;
                if (key_load) begin
                    key_acc  = 1'b1;
                    state_nx = KEYEXP;
                end else if (in_valid) begin
                    ct_acc   = 1'b1;
                    state_nx = DEC;
                end
            end
            DEC: begin
                if (rcnt == 5'd0) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = READY;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            kcnt  <= '0;
            rcnt  <= '0;
            x     <= '0;
            y     <= '0;
            for (int i = 0; i < 32; i++) rk[i] <= '0;
        end else begin
            state <= state_nx;
            if (key_acc) begin
                rk[0] <= keytext[15:0];
                rk[1] <= keytext[31:16];
                rk[2] <= keytext[47:32];
                rk[3] <= keytext[63:48];
                kcnt  <= 5'd4;
            end else if (state == KEYEXP) begin
                rk[kcnt] <= knew;
                if (kcnt != 5'd31) kcnt <= kcnt + 5'd1;
            end
            if (ct_acc) begin
                x    <= ciphertext[31:16];
                y    <= ciphertext[15:0];
                rcnt <= 5'd31;
            end else if (state == DEC) begin
                x <= y;
                y <= ynew;
                if (rcnt != 5'd0) rcnt <= rcnt - 5'd1;
            end
        end
    end

    assign plaintext = {x, y};

endmodule

// File: tb/tb_simon_decrypt_iter.sv
// Bench for simon_decrypt_iter: directed vectors checked against
// a reference Simon32/64 encryptor kept in the bench.
module tb_simon_decrypt_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_load = 1'b0;
    logic [63:0] keytext = '0;
    logic        key_ready;
    logic        in_valid = 1'b0;
    logic [31:0] ciphertext = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] plaintext;
    logic        out_ready = 1'b1;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pt = '0;
    logic        exp_on = 1'b0;

    localparam logic [63:0] K0 = 64'h1918_1110_0908_0100;
    localparam logic [63:0] K1 = 64'h0f0e_0d0c_0b0a_0908;
    localparam logic [63:0] K2 = 64'hdead_beef_cafe_f00d;
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    simon_decrypt_iter dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .keytext    (keytext),
        .key_ready  (key_ready),
        .in_valid   (in_valid),
        .ciphertext (ciphertext),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .plaintext  (plaintext),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    // reference Simon32/64 encryption, straight from the cipher definition
    function automatic logic [31:0] enc(input logic [31:0] pt,
                                        input logic [63:0] key);
        logic [15:0] k [32];
        logic [15:0] t;
        logic [15:0] a;
        logic [15:0] b;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rotl(k[i-1], 13) ^ k[i-3];
            t = t ^ rotl(t, 15);
            k[i] = 16'hfffc ^ k[i-4] ^ t ^ {15'd0, Z0[61-(i-4)]};
        end
        a = pt[31:16];
        b = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = a;
            a = b ^ (rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2) ^ k[i];
            b = t;
        end
        return {a, b};
    endfunction

    always @(negedge clk) begin
        if (rst && exp_on && out_valid)
            chk("model_pt", plaintext, exp_pt);
        if (rst && out_valid && in_ready)
            chk("excl_valid_ready", 1'b1, 1'b0);
    end

    task automatic load_key(input logic [63:0] k, input logic with_ct,
                            input string tag);
        int n;
        n = 0;
        while (!key_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_krdy"}, key_ready, 1);
        keytext    = k;
        key_load   = 1'b1;
        in_valid   = with_ct;
        ciphertext = 32'hffff_ffff;
        @(posedge clk); #1;
        key_load = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_acc"}, {key_ready, in_ready, out_valid}, 3'b000);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (out_valid) chk({tag, "_noct"}, out_valid, 0);
        end while (!in_ready && n < 40);
        chk({tag, "_keyexp_len"}, n, 28);
    endtask

    task automatic decrypt(input logic [31:0] ct, input logic [31:0] pt,
                           input int hold, input int kl_at,
                           input int rst_at, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_inrdy"}, in_ready, 1);
        exp_pt     = pt;
        exp_on     = 1'b1;
        out_ready  = (hold == 0);
        ciphertext = ct;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n == rst_at) begin
                rst = 1'b0;
                #1;
                chk({tag, "_rst_outs"},
                    {key_ready, in_ready, out_valid, plaintext},
                    {1'b1, 1'b0, 1'b0, 32'h0});
                exp_on    = 1'b0;
                out_ready = 1'b1;
                return;
            end
            if (kl_at > 0 && n == kl_at) begin
                keytext  = K1;
                key_load = 1'b1;
                chk({tag, "_dec_krdy"}, key_ready, 0);
            end
            if (kl_at > 0 && n == kl_at + 2) key_load = 1'b0;
        end while (!out_valid && n < 40);
        chk({tag, "_latency"}, n, 32);
        chk({tag, "_pt"}, plaintext, pt);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, {out_valid, in_ready, plaintext},
                {1'b1, 1'b0, pt});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_back"}, {out_valid, in_ready}, 2'b01);
        exp_on = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok;
        logic [63:0] rk;
        logic [31:0] rp;

        chk("pin_enc_kat", enc(32'h6565_6877, K0), 32'hc69b_e9bb);

        #2 rst = 1'b0;
        #1;
        chk("reset_outs", {key_ready, in_ready, out_valid, plaintext},
            {1'b1, 1'b0, 1'b0, 32'h0});

        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        ok       = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
            if (in_ready || out_valid) ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("nokey_quiet", ok, 1);

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        load_key(K0, 1'b0, "k0");
        decrypt(32'hc69b_e9bb, 32'h6565_6877, 10, 0, 0, "kat_hold");
        decrypt(32'hc69b_e9bb, 32'h6565_6877, 0, 0, 0, "kat");

        decrypt(32'hc69b_e9bb, 32'h6565_6877, 0, 5, 0, "kl_in_dec");
        load_key(K1, 1'b0, "k1");
        decrypt(enc(32'h1234_5678, K1), 32'h1234_5678, 0, 0, 0, "k1");

        load_key(K2, 1'b1, "both");
        decrypt(enc(32'h0bad_c0de, K2), 32'h0bad_c0de, 0, 0, 0, "k2");

        decrypt(enc(32'h5555_aaaa, K2), 32'h5555_aaaa, 0, 0, 10, "abort");
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        ok       = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (in_ready || out_valid) ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("abort_nokey", ok, 1);
        load_key(K0, 1'b0, "k0b");
        decrypt(32'hc69b_e9bb, 32'h6565_6877, 0, 0, 0, "kat_again");

        for (int i = 0; i < 3; i++) begin
            rk = {$urandom, $urandom};
            rp = $urandom;
            load_key(rk, 1'b0, "rnd");
            decrypt(enc(rp, rk), rp, 0, 0, 0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
